// File: rtl/spectrum_agc_ctrl_pkg.sv
// Shared types and helpers for the spectrum-path automatic gain controller.
// Holds the controller state encoding, the internal shift width and the leading-one search.
package spectrum_agc_ctrl_pkg;

    localparam int COEFF_W = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        CALC   = 2'd2,
        DECIDE = 2'd3
    } agc_state_e;

    // Index of the highest set bit; an all-zero word reports position 0.
    function automatic logic [4:0] msb_pos(input logic [31:0] val);
        logic [4:0] pos;
        pos = '0;
        for (int i = 0; i < 32; i++) begin
            if (val[i]) pos = i[4:0];
        end
        return pos;
    endfunction

endpackage

// File: rtl/agc_msb_encode.sv
// Registered 32-bit leading-one priority encoder.
// One cycle latency; free-running, no flow control.
module agc_msb_encode
    import spectrum_agc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] val_i,
    output logic [4:0]  msb_o
);

    logic [4:0] msb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) msb_q <= '0;
        else     msb_q <= msb_pos(val_i);
    end

    assign msb_o = msb_q;

endmodule

// File: rtl/spectrum_agc_ctrl.sv
// Per-frame peak tracker driving the gain-stage bit-select shift (fast attack, held decay).
// Peak is reported one cycle after the last sample; a new shift appears three cycles after it.
module spectrum_agc_ctrl
    import spectrum_agc_ctrl_pkg::*;
#(
    parameter int BITWIDTH    = 7,
    parameter int FFT_POINT   = 512,
    parameter int HEADROOM    = 1,
    parameter int HOLD_FRAMES = 8,
    parameter int COEFF_MAX   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_sync_in,
    input  logic [BITWIDTH+1:0]   cnt_sync_in,
    input  logic [31:0]           para_in0,
    input  logic                  agc_en,
    input  logic [15:0]           manual_coeff,
    output logic [15:0]           scaled_coeff,
    output logic                  coeff_update,
    output logic [31:0]           frame_peak,
    output logic                  peak_valid
);

    localparam int                 CNT_W    = BITWIDTH + 2;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FFT_POINT - 1);
    localparam logic [COEFF_W-1:0] TARGET   = COEFF_W'(15 - HEADROOM);
    localparam logic [COEFF_W-1:0] CMAX     = COEFF_W'(COEFF_MAX);
    localparam logic [7:0]         HOLD_LIM = 8'(HOLD_FRAMES);

    agc_state_e         state_q, state_d;
    logic               frame_act_q, frame_act_d;
    logic [31:0]        acc_q, acc_d;
    logic [31:0]        frame_peak_q, frame_peak_d;
    logic               peak_vld_q, peak_vld_d;
    logic [COEFF_W-1:0] cand_q, cand_d;
    logic [COEFF_W-1:0] coeff_q, coeff_d;
    logic               coeff_upd_q, coeff_upd_d;
    logic [7:0]         hold_q, hold_d;
    logic               frame_done;
    logic [31:0]        sample_max;
    logic [4:0]         msb;
    logic [COEFF_W-1:0] msb_ext;
    logic [7:0]         hold_inc;

    assign sample_max = (para_in0 > acc_q) ? para_in0 : acc_q;

    // Capture path runs independently of CALC/DECIDE so back-to-back frames lose nothing.
    always_comb begin
        acc_d        = acc_q;
        frame_act_d  = frame_act_q;
        frame_peak_d = frame_peak_q;
        peak_vld_d   = 1'b0;
        frame_done   = 1'b0;
        if (en_sync_in) begin
            if (cnt_sync_in == '0) begin
                acc_d       = para_in0;
                frame_act_d = 1'b1;
            end else if (frame_act_q) begin
                acc_d = sample_max;
                if (cnt_sync_in == CNT_LAST) begin
                    frame_peak_d = sample_max;
                    peak_vld_d   = 1'b1;
                    frame_act_d  = 1'b0;
                    frame_done   = 1'b1;
                end
            end
        end
    end

    // Encoder sees the peak as it is written, so its result is ready during CALC.
    agc_msb_encode u_msb_encode (
        .clk   (clk),
        .rst   (rst),
        .val_i (frame_peak_d),
        .msb_o (msb)
    );

    assign msb_ext  = {1'b0, msb};
    assign hold_inc = hold_q + 8'd1;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        coeff_d = coeff_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (frame_done)       state_d = CALC;
                else if (frame_act_d) state_d = ACCUM;
                else                  state_d = IDLE;
            end
            CALC: begin
                cand_d = (msb_ext > TARGET) ? (msb_ext - TARGET) : '0;
                if (cand_d > CMAX) cand_d = CMAX;
                state_d = DECIDE;
            end
            DECIDE: begin
                if (agc_en) begin
                    if (cand_q > coeff_q) begin
                        coeff_d = cand_q;
                        hold_d  = '0;
                    end else if (cand_q == coeff_q) begin
                        hold_d = '0;
                    end else if (hold_inc >= HOLD_LIM) begin
                        coeff_d = cand_q;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_inc;
                    end
                end
                state_d = frame_act_d ? ACCUM : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!agc_en) begin
            coeff_d = (manual_coeff > 16'(COEFF_MAX)) ? CMAX : manual_coeff[COEFF_W-1:0];
            hold_d  = '0;
        end
    end

    assign coeff_upd_d = (coeff_d != coeff_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            frame_act_q  <= 1'b0;
            acc_q        <= '0;
            frame_peak_q <= '0;
            peak_vld_q   <= 1'b0;
            cand_q       <= '0;
            coeff_q      <= '0;
            coeff_upd_q  <= 1'b0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            frame_act_q  <= frame_act_d;
            acc_q        <= acc_d;
            frame_peak_q <= frame_peak_d;
            peak_vld_q   <= peak_vld_d;
            cand_q       <= cand_d;
            coeff_q      <= coeff_d;
            coeff_upd_q  <= coeff_upd_d;
            hold_q       <= hold_d;
        end
    end

    assign scaled_coeff = {{(16-COEFF_W){1'b0}}, coeff_q};
    assign coeff_update = coeff_upd_q;
    assign frame_peak   = frame_peak_q;
    assign peak_valid   = peak_vld_q;

endmodule

// File: tb/tb_spectrum_agc_ctrl.sv
// Scoreboard bench for spectrum_agc_ctrl: a frame-level reference model queues expected
// peak/shift results as samples are driven, and a monitor checks them as peak_valid appears.
module tb_spectrum_agc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_sync_in;
    logic [8:0]  cnt_sync_in;
    logic [31:0] para_in0;
    logic        agc_en;
    logic [15:0] manual_coeff;
    logic [15:0] scaled_coeff;
    logic        coeff_update;
    logic [31:0] frame_peak;
    logic        peak_valid;

    spectrum_agc_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .en_sync_in   (en_sync_in),
        .cnt_sync_in  (cnt_sync_in),
        .para_in0     (para_in0),
        .agc_en       (agc_en),
        .manual_coeff (manual_coeff),
        .scaled_coeff (scaled_coeff),
        .coeff_update (coeff_update),
        .frame_peak   (frame_peak),
        .peak_valid   (peak_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] peak;
        int          prev;
        int          coeff;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] fq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cur_m   = 0;
    int          hold_m  = 0;
    bit          act_m   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: peak is the max of the stored samples; shift follows the attack/decay rules.
    task automatic model_frame_end();
        logic [31:0] pk;
        int m, cand;
        exp_t e;
        pk = 0;
        foreach (fq[i]) if (fq[i] > pk) pk = fq[i];
        m = 0;
        for (int i = 0; i < 32; i++) if (pk[i]) m = i;
        cand = (m > 14) ? m - 14 : 0;
        if (cand > 16) cand = 16;
        e.peak = pk;
        e.prev = cur_m;
        if (agc_en) begin
            if (cand > cur_m) begin
                cur_m = cand; hold_m = 0;
            end else if (cand == cur_m) begin
                hold_m = 0;
            end else begin
                hold_m++;
                if (hold_m == 8) begin cur_m = cand; hold_m = 0; end
            end
        end
        e.coeff = cur_m;
        sb.push_back(e);
        fq.delete();
    endtask

    task automatic send(input int cnt, input logic [31:0] d);
        @(negedge clk);
        en_sync_in  = 1'b1;
        cnt_sync_in = cnt[8:0];
        para_in0    = d;
        if (cnt == 0) begin
            fq.delete(); fq.push_back(d); act_m = 1;
        end else if (act_m) begin
            fq.push_back(d);
            if (cnt == 511) begin act_m = 0; model_frame_end(); end
        end
    endtask

    // Gap cycles carry junk index/data that must be ignored.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            en_sync_in  = 1'b0;
            cnt_sync_in = 9'($urandom);
            para_in0    = $urandom;
        end
    endtask

    task automatic frame_pk(input logic [31:0] pk, input int idx, input logic [31:0] fill, input bit gaps);
        for (int c = 0; c < 512; c++) begin
            if (gaps && $urandom_range(0, 15) == 0) idle($urandom_range(1, 3));
            send(c, (c == idx) ? pk : fill);
        end
    endtask

    task automatic rand_frame(input bit gaps);
        int sh;
        sh = $urandom_range(0, 31);
        for (int c = 0; c < 512; c++) begin
            if (gaps && $urandom_range(0, 15) == 0) idle($urandom_range(1, 3));
            send(c, $urandom >> sh);
        end
    endtask

    task automatic set_mode(input logic en, input logic [15:0] man);
        int exp;
        @(negedge clk);
        en_sync_in   = 1'b0;
        agc_en       = en;
        manual_coeff = man;
        if (!en) begin
            exp = (man > 16) ? 16 : int'(man);
            @(negedge clk);
            chk("manual_coeff", scaled_coeff, exp);
            chk("manual_update", coeff_update, (exp != cur_m));
            cur_m = exp;
        end
        hold_m = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && peak_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_peak_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("frame_peak", frame_peak, e.peak);
                    @(negedge clk);
                    chk("coeff_before_update", scaled_coeff, e.prev);
                    @(negedge clk);
                    chk("coeff_T3", scaled_coeff, e.coeff);
                    chk("coeff_update_T3", coeff_update, (e.coeff != e.prev));
                end
            end
        end
    end

    initial begin : watchdog
        #1_500_000;
        chk("watchdog_timeout", 1, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : stim
        rst = 1'b1; en_sync_in = 1'b0; cnt_sync_in = '0; para_in0 = '0;
        agc_en = 1'b1; manual_coeff = '0;
        #22;
        chk("rst_coeff", scaled_coeff, 0);
        chk("rst_update", coeff_update, 0);
        chk("rst_peak", frame_peak, 0);
        chk("rst_peak_valid", peak_valid, 0);
        @(negedge clk); rst = 1'b0;
        idle(3);

        frame_pk(32'h0001_2345, 100, 32'h10, 0);
        idle(5);
        frame_pk(32'h8000_0000, 7, 32'h10, 0);
        frame_pk(32'h0000_1000, 9, 32'h10, 0);
        idle(5);

        set_mode(0, 16'd6);
        set_mode(1, 16'd0);
        repeat (8) frame_pk(32'h0000_4000, 33, 32'h10, 0);
        idle(5);
        frame_pk(32'h0010_0000, 200, 32'h10, 0);
        repeat (4) frame_pk(32'h0000_4000, 33, 32'h10, 0);
        frame_pk(32'h0010_0000, 480, 32'h10, 0);
        repeat (8) frame_pk(32'h0000_4000, 33, 32'h10, 0);
        idle(5);

        frame_pk(32'h0001_0000, 5, 32'h10, 0);
        repeat (5) frame_pk(32'h0000_4000, 60, 32'h10, 0);
        frame_pk(32'h0400_0000, 511, 32'h10, 0);
        idle(5);

        repeat (20) rand_frame(0);
        idle(5);
        repeat (4) rand_frame(1);
        idle(5);

        for (int c = 0; c <= 300; c++) send(c, (c == 50) ? 32'hFFFF_FFFF : 32'h20);
        frame_pk(32'h0002_0000, 400, 32'h20, 0);
        idle(5);

        set_mode(0, 16'd20);
        frame_pk(32'h0000_0100, 3, 32'h10, 1);
        set_mode(1, 16'd0);
        frame_pk(32'h0001_0000, 3, 32'h10, 0);
        idle(5);

        for (int c = 0; c <= 200; c++) send(c, 32'h0100_0000 + c);
        #1;
        rst = 1'b1; en_sync_in = 1'b0;
        #1;
        chk("async_rst_coeff", scaled_coeff, 0);
        chk("async_rst_update", coeff_update, 0);
        chk("async_rst_peak", frame_peak, 0);
        chk("async_rst_peak_valid", peak_valid, 0);
        fq.delete(); act_m = 0; cur_m = 0; hold_m = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(2);
        frame_pk(32'h0001_2345, 100, 32'h10, 0);
        idle(10);

        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
